uart_tx_engine: RTL

//  Single-clock UART transmit engine, the transmit counterpart of the RX path in the UART driver.

---
 rtl/uart_tx_engine.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/uart_tx_engine.sv
// UART transmit engine: valid/ready byte intake, CTS-gated frame start,
// per-bit clock divider, 5-8 data bits LSB first, optional parity, 1/1.5/2 stops.
module uart_tx_engine #(
  parameter int unsigned P_CTS_EN      = 1,
  parameter int unsigned P_SYNC_STAGES = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [7:0]  i_user_tx_data,
  input  logic        i_user_tx_valid,
  output logic        o_user_tx_ready,
  input  logic        i_uart_cts,
  output logic        o_uart_tx,
  output logic        o_tx_busy,
  input  logic [23:0] i_div_num,
  input  logic [3:0]  i_data_bit,
  input  logic [1:0]  i_stop_bit,
  input  logic [1:0]  i_check_bit
);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t state_q;

  logic [P_SYNC_STAGES-1:0] cts_sync;
  logic                     cts_s;

  logic        ready_q;
  logic        tx_q;
  logic        busy_q;

  logic [23:0] div_q;
  logic [3:0]  nbits_q;
  logic [1:0]  stop_q;
  logic        par_en_q;
  logic        par_bit_q;
  logic [7:0]  shift_q;
  logic [3:0]  bit_idx_q;
  logic [23:0] cnt_q;
  logic        stop_ext_q;

  logic [23:0] cfg_div;
  logic [3:0]  cfg_bits;
  logic [7:0]  cfg_mask;
  logic [7:0]  data_masked;
  logic        cfg_par_en;
  logic        cfg_par_bit;

  logic [23:0] cnt_limit;
  logic        cnt_last;

  // CTS synchroniser chain into the clock domain
  always_ff @(posedge clock) begin
    if (reset) begin
      cts_sync <= '0;
    end else begin
      cts_sync <= {cts_sync[P_SYNC_STAGES-2:0], i_uart_cts};
    end
  end

  assign cts_s = (P_CTS_EN != 0) ? cts_sync[P_SYNC_STAGES-1] : 1'b1;

  // Decode the live configuration inputs into the values latched at transfer
  always_comb begin
    cfg_div = i_div_num;
    if (i_div_num < 24'd2) begin
      cfg_div = 24'd2;
    end
    case (i_data_bit)
      4'd5:    begin cfg_bits = 4'd5; cfg_mask = 8'h1F; end
      4'd6:    begin cfg_bits = 4'd6; cfg_mask = 8'h3F; end
      4'd7:    begin cfg_bits = 4'd7; cfg_mask = 8'h7F; end
      default: begin cfg_bits = 4'd8; cfg_mask = 8'hFF; end
    endcase
    data_masked = i_user_tx_data & cfg_mask;
    cfg_par_en  = (i_check_bit == 2'd1) || (i_check_bit == 2'd2);
    cfg_par_bit = (i_check_bit == 2'd2) ? (^data_masked) : ~(^data_masked);
  end

  // Bit-period terminal count; the extra half stop period uses D/2
  always_comb begin
    cnt_limit = div_q;
    if ((state_q == STOP) && stop_ext_q && (stop_q == 2'd1)) begin
      cnt_limit = div_q >> 1;
    end
    cnt_last = (cnt_q == (cnt_limit - 24'd1));
  end

  // Frame sequencer with registered line, busy and ready outputs.
  // Stop time is split into a full period plus an optional extension period
  // (D/2 or D) so the 24-bit bit counter never has to reach 2*D.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      ready_q    <= 1'b0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      div_q      <= 24'd2;
      nbits_q    <= 4'd8;
      stop_q     <= '0;
      par_en_q   <= 1'b0;
      par_bit_q  <= 1'b0;
      shift_q    <= '0;
      bit_idx_q  <= '0;
      cnt_q      <= '0;
      stop_ext_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (i_user_tx_valid && ready_q) begin
            div_q      <= cfg_div;
            nbits_q    <= cfg_bits;
            stop_q     <= i_stop_bit;
            par_en_q   <= cfg_par_en;
            par_bit_q  <= cfg_par_bit;
            shift_q    <= data_masked;
            bit_idx_q  <= '0;
            cnt_q      <= '0;
            stop_ext_q <= 1'b0;
            ready_q    <= 1'b0;
            tx_q       <= 1'b0;
            busy_q     <= 1'b1;
            state_q    <= START;
          end else begin
            ready_q <= cts_s;
          end
        end
        START: begin
          if (cnt_last) begin
            cnt_q   <= '0;
            tx_q    <= shift_q[0];
            state_q <= DATA;
          end else begin
            cnt_q <= cnt_q + 24'd1;
          end
        end
        DATA: begin
          if (cnt_last) begin
            cnt_q <= '0;
            if (bit_idx_q == (nbits_q - 4'd1)) begin
              if (par_en_q) begin
                tx_q    <= par_bit_q;
                state_q <= PARITY;
              end else begin
                tx_q    <= 1'b1;
                state_q <= STOP;
              end
            end else begin
              bit_idx_q <= bit_idx_q + 4'd1;
              shift_q   <= shift_q >> 1;
              tx_q      <= shift_q[1];
            end
          end else begin
            cnt_q <= cnt_q + 24'd1;
          end
        end
        PARITY: begin
          if (cnt_last) begin
            cnt_q   <= '0;
            tx_q    <= 1'b1;
            state_q <= STOP;
          end else begin
            cnt_q <= cnt_q + 24'd1;
          end
        end
        STOP: begin
          if (cnt_last) begin
            cnt_q <= '0;
            if (!stop_ext_q && (stop_q != 2'd0)) begin
              stop_ext_q <= 1'b1;
            end else begin
              stop_ext_q <= 1'b0;
              busy_q     <= 1'b0;
              ready_q    <= cts_s;
              state_q    <= IDLE;
            end
          end else begin
            cnt_q <= cnt_q + 24'd1;
          end
        end
        default: begin
          state_q <= IDLE;
          tx_q    <= 1'b1;
          busy_q  <= 1'b0;
          ready_q <= 1'b0;
        end
      endcase
    end
  end

  assign o_user_tx_ready = ready_q;
  assign o_uart_tx       = tx_q;
  assign o_tx_busy       = busy_q;

endmodule
